adc_scan_sequencer: RTL
=======================

ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 Parameter NCH, 4, number of multiplexed analog channels (channel index width 2).
REQ-002 Parameter SETTLE, 3, mux settling cycles before each conversion request (1..15).
REQ-003 Parameter TIMEOUT, 20, max cycles in CONVERT waiting for adc_done (1..63).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 clr  input  1  reset, asynchronous, active-low.
REQ-006 enable  input  1  level; scanning permitted while high.
REQ-007 continuous  input  1  1 = restart scan after completion; 0 = single scan per enable rising edge.
REQ-008 chan_mask  input  4  channels to convert; bit i = channel i.
REQ-009 adc_done  input  1  one-cycle conversion-complete pulse from SAR controller.
REQ-010 adc_data  input  8  conversion result, valid while adc_done is high.
REQ-011 mux_sel  output  2  analog mux channel select.
REQ-012 adc_start  output  1  registered conversion request level to SAR controller.
REQ-013 rd_en  input  1  consume result of channel rd_sel.
REQ-014 rd_sel  input  2  read channel index.
REQ-015 rd_data  output  8  combinational: stored result of channel rd_sel.
REQ-016 valid  output  4  per-channel unread-result flags.
REQ-017 overrun  output  4  per-channel sticky flags: unread result overwritten.
REQ-018 timeout_err  output  4  per-channel sticky flags: conversion timed out.
REQ-019 scan_done  output  1  one-cycle pulse at end of every scan.

Function
REQ-020 FSM states: IDLE, SELECT, SETTLE, CONVERT, STORE; one-hot or binary is implementer's choice.
REQ-021 IDLE -> SELECT when enable=1, chan_mask!=0, and (continuous=1 or enable rising edge detected); chan_mask latched into scan_mask on this transition.
REQ-022 SELECT: pick lowest set bit of scan_mask at or above current pointer; drive mux_sel to it, clear settle counter, go SETTLE (1 cycle in SELECT).
REQ-023 SETTLE: hold mux_sel, count SETTLE cycles, then go CONVERT with adc_start=1 registered on entry.
REQ-024 CONVERT: adc_start held 1 until adc_done sampled; on adc_done, capture adc_data into result[mux_sel], adc_start=0 next cycle, go STORE.
REQ-025 CONVERT timeout: if adc_done not seen within TIMEOUT cycles, set timeout_err[mux_sel], adc_start=0, result and valid unchanged, go STORE.
REQ-026 STORE: clear scan_mask bit of current channel; if more bits remain and enable=1 go SELECT; else pulse scan_done and go SELECT (continuous=1, enable=1, relatch chan_mask, pointer=0) or IDLE.
REQ-027 Capture sets valid[ch]; if valid[ch] already 1 at capture, set overrun[ch].
REQ-028 rd_en clears valid[rd_sel] and overrun[rd_sel]; timeout_err cleared only by reset.
REQ-029 rd_en to channel being captured same cycle: capture wins, valid=1, overrun not set; rd_data shows old value that cycle.
REQ-030 enable falling mid-scan: current conversion completes (or times out), result stored, scan_done pulsed, -> IDLE; no further adc_start.
REQ-031 chan_mask changes mid-scan ignored until next latch.
REQ-032 enable=1 with chan_mask=0: remain IDLE, adc_start=0, no scan_done.
REQ-033 adc_done outside CONVERT ignored.
REQ-034 Per-channel latency enable->adc_start = SELECT 1 + SETTLE cycles; mux_sel never changes while adc_start=1.

Reset
REQ-035 clr=0: state IDLE, mux_sel=0, adc_start=0, scan_done=0, valid=0, overrun=0, timeout_err=0, result array=0, pointer=0, counters=0.
REQ-036 Reset mid-conversion aborts immediately; no partial result stored.

Verification
REQ-037 mask=4'b0101, continuous=0, enable rise, ADC model done after 11 cycles with data 0x3C, 0xA5 -> mux_sel 0 then 2, result[0]=0x3C, result[2]=0xA5, valid=4'b0101, one scan_done, then IDLE.
REQ-038 continuous=1, mask=4'b0001, no reads across two scans -> overrun[0]=1 after second capture; rd_en rd_sel=0 clears valid[0] and overrun[0].
REQ-039 ADC model never pulses adc_done, mask=4'b0010 -> after TIMEOUT cycles timeout_err[1]=1, valid[1]=0, adc_start=0, scan_done pulses.
REQ-040 enable drops during channel 1 CONVERT with mask=4'b1110 -> channel 1 stored, channels 2,3 never selected, scan_done once, IDLE.
REQ-041 rd_en rd_sel=3 coincident with adc_done on channel 3 (valid[3]=1) -> valid[3]=1, overrun[3]=0, new data stored.
REQ-042 clr asserted mid-SETTLE and mid-CONVERT -> all outputs at reset values same cycle; later adc_done ignored.

Source files
------------

// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - multiplexed ADC channel scan sequencer with per-channel result store
module adc_scan_sequencer #(
  parameter int NCH = 4,
  parameter int SETTLE = 3,
  parameter int TIMEOUT = 20,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           enable,
  input  logic           continuous,
  input  logic [NCH-1:0] chan_mask,
  input  logic           adc_done,
  input  logic [7:0]     adc_data,
  output logic [CW-1:0]  mux_sel,
  output logic           adc_start,
  input  logic           rd_en,
  input  logic [CW-1:0]  rd_sel,
  output logic [7:0]     rd_data,
  output logic [NCH-1:0] valid,
  output logic [NCH-1:0] overrun,
  output logic [NCH-1:0] timeout_err,
  output logic           scan_done
);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_SETTLE, S_CONVERT, S_STORE} state_t;

  state_t         state;
  logic           enable_q;
  logic [NCH-1:0] scan_mask;
  logic [CW-1:0]  pointer;
  logic [CW-1:0]  next_ch;
  logic [3:0]     settle_cnt;
  logic [5:0]     tmo_cnt;
  logic [7:0]     result [NCH];
  logic           capture;
  logic           start_ok;
  logic [NCH-1:0] remaining;
  logic [NCH-1:0] cap_hits;
  logic [NCH-1:0] rd_hits;

  assign rd_data   = result[rd_sel];
  assign capture   = (state == S_CONVERT) && adc_done;
  assign start_ok  = enable && (chan_mask != '0) && (continuous || !enable_q);
  assign remaining = scan_mask & ~(NCH'(1) << mux_sel);
  assign cap_hits  = capture ? (NCH'(1) << mux_sel) : '0;
  assign rd_hits   = rd_en ? (NCH'(1) << rd_sel) : '0;

  // Lowest pending channel at or above the scan pointer
  always_comb begin
    next_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (scan_mask[i] && (i >= int'(pointer))) next_ch = CW'(i);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state       <= S_IDLE;
      enable_q    <= 1'b0;
      scan_mask   <= '0;
      pointer     <= '0;
      mux_sel     <= '0;
      settle_cnt  <= '0;
      tmo_cnt     <= '0;
      adc_start   <= 1'b0;
      scan_done   <= 1'b0;
      timeout_err <= '0;
    end else begin
      enable_q  <= enable;
      scan_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            scan_mask <= chan_mask;
            pointer   <= '0;
            state     <= S_SELECT;
          end
        end
        S_SELECT: begin
          mux_sel    <= next_ch;
          settle_cnt <= '0;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == 4'(SETTLE - 1)) begin
            adc_start <= 1'b1;
            tmo_cnt   <= '0;
            state     <= S_CONVERT;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        S_CONVERT: begin
          if (adc_done) begin
            adc_start <= 1'b0;
            state     <= S_STORE;
          end else if (tmo_cnt == 6'(TIMEOUT - 1)) begin
            adc_start            <= 1'b0;
            timeout_err[mux_sel] <= 1'b1;
            state                <= S_STORE;
          end else begin
            tmo_cnt <= tmo_cnt + 6'd1;
          end
        end
        S_STORE: begin
          scan_mask <= remaining;
          if ((remaining != '0) && enable) begin
            pointer <= mux_sel + CW'(1);
            state   <= S_SELECT;
          end else begin
            scan_done <= 1'b1;
            if (continuous && enable && (chan_mask != '0)) begin
              scan_mask <= chan_mask;
              pointer   <= '0;
              state     <= S_SELECT;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A read racing a capture on the same channel consumed the old data, so it is not an overrun
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      valid   <= '0;
      overrun <= '0;
      for (int i = 0; i < NCH; i++) result[i] <= '0;
    end else begin
      if (capture) result[mux_sel] <= adc_data;
      valid   <= (valid & ~rd_hits) | cap_hits;
      overrun <= (overrun | (valid & cap_hits)) & ~rd_hits;
    end
  end

endmodule
